// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one cacheline memory port between I-cache and D-cache, one whole transaction at a time.
module cache_mem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter bit D_FIRST      = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_read,
  input  logic [31:0]  i_address,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [31:0]  d_address,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic         busy
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic d_req, d_wins, in_i, in_d;
  assign d_req = d_read | d_write;
  // D takes a tie only while the I side has not yet lost STARVE_LIMIT cycles
  assign d_wins = d_req & (~i_read | (D_FIRST && (wait_cnt_q < CW'(STARVE_LIMIT))));
  assign in_i = (state_q == SERVE_I);
  assign in_d = (state_q == SERVE_D);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = d_wins ? SERVE_D : (i_read ? SERVE_I : IDLE);
      SERVE_I: state_d = pmem_resp ? IDLE : SERVE_I;
      SERVE_D: state_d = pmem_resp ? IDLE : SERVE_D;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!D_FIRST || (state_q == IDLE && state_d == SERVE_I))
      wait_cnt_d = '0;
    else if (i_read && !in_i && wait_cnt_q != CW'(STARVE_LIMIT))
      wait_cnt_d = wait_cnt_q + CW'(1);
  end
  always_comb begin
    busy         = (state_q != IDLE);
    pmem_read    = in_i | (in_d & d_read & ~d_write);
    pmem_write   = in_d & d_write;
    pmem_address = in_i ? {i_address[31:5], 5'b0} : (in_d ? {d_address[31:5], 5'b0} : 32'b0);
    pmem_wdata   = in_d ? d_wdata : '0;
    i_resp       = in_i & pmem_resp & ~rst;
    d_resp       = in_d & pmem_resp & ~rst;
    i_rdata      = i_resp ? pmem_rdata : '0;
    d_rdata      = d_resp ? pmem_rdata : '0;
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: table-driven vectors plus hand sequences, with a per-port scoreboard and a latency-programmable memory model.
module tb_cache_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic i_read = 0, d_read = 0, d_write = 0, pmem_resp = 0, stray = 0;
  logic [31:0] i_address = 0, d_address = 0;
  logic [255:0] d_wdata = 0, pmem_rdata = 0;
  logic [255:0] i_rdata, d_rdata, pmem_wdata;
  logic i_resp, d_resp, pmem_read, pmem_write, busy;
  logic [31:0] pmem_address;
  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst), .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_resp(d_resp), .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .busy(busy)
  );

  typedef struct { logic wr; logic [31:0] addr; logic [255:0] wdata; } txn_t;
  typedef struct { logic ir; logic [31:0] ia; logic dr; logic dw; logic [31:0] da; logic [255:0] dwd; int lat; int first; } vec_t;
  txn_t iq[$], dq[$];
  vec_t v[6];
  int checks = 0, failures = 0, lat = 3, mcnt = 0, first_resp = -1, d_reissue = 0, d_count = 0, i_count = 0;
  logic prev_resp = 0;

  function automatic logic [255:0] line(input logic [31:0] a);
    return {4{a, ~a}};
  endfunction

  task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask

  task automatic req_i(input logic [31:0] a);
    i_read = 1; i_address = a;
    iq.push_back('{1'b0, {a[31:5], 5'b0}, 256'b0});
  endtask

  task automatic req_d(input logic rd, input logic wr, input logic [31:0] a, input logic [255:0] w);
    d_read = rd; d_write = wr; d_address = a; d_wdata = w;
    dq.push_back('{wr, {a[31:5], 5'b0}, w});
  endtask

  // memory model updates after the edge; requester/monitor act on the falling edge
  task automatic step();
    txn_t t;
    @(posedge clk); #2;
    if (rst || !(pmem_read || pmem_write)) mcnt = 0; else mcnt++;
    pmem_resp = (mcnt != 0 && mcnt == lat) || stray;
    pmem_rdata = pmem_resp ? line(pmem_address) : ~line(pmem_address);
    @(negedge clk);
    if (prev_resp) chk("turnaround_idle", busy, 0);
    prev_resp = i_resp | d_resp;
    if (i_resp) begin
      chk("resp_exclusive", d_resp, 0);
      if (iq.size() == 0) chk("unexpected_i_resp", i_resp, 0);
      else begin
        t = iq.pop_front();
        chk("i_addr", pmem_address, t.addr);
        chk("i_strobe", {pmem_read, pmem_write}, 2'b10);
        chk("i_rdata", i_rdata, line(t.addr));
      end
      i_count++;
      if (first_resp < 0) first_resp = 0;
      i_read = 0;
    end
    if (d_resp) begin
      if (dq.size() == 0) chk("unexpected_d_resp", d_resp, 0);
      else begin
        t = dq.pop_front();
        chk("d_addr", pmem_address, t.addr);
        chk("d_strobe", {pmem_read, pmem_write}, t.wr ? 2'b01 : 2'b10);
        if (t.wr) chk("d_wdata", pmem_wdata, t.wdata);
        else chk("d_rdata", d_rdata, line(t.addr));
      end
      d_count++;
      if (first_resp < 0) first_resp = 1;
      if (d_reissue > 0) begin
        d_reissue--;
        req_d(1'b1, 1'b0, d_address + 32'd64, 256'b0);
      end else begin
        d_read = 0; d_write = 0;
      end
    end
  endtask

  task automatic drain(input string n);
    int k = 0;
    while ((iq.size() != 0 || dq.size() != 0 || busy) && k < 100) begin
      step();
      k++;
    end
    chk(n, k < 100, 1);
  endtask

  initial begin
    int c0;
    v[0] = '{1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0, 256'h0, 3, 0};
    v[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0040, {32{8'hA5}}, 2, 1};
    v[2] = '{1'b1, 32'h0000_2000, 1'b1, 1'b0, 32'h0000_5020, 256'h0, 3, 1};
    v[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0FFF, 256'h0, 1, 1};
    v[4] = '{1'b1, 32'h1234_567F, 1'b0, 1'b1, 32'hCAFE_0000, {8{32'h1357_9BDF}}, 2, 1};
    v[5] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 256'h0, 4, 0};
    repeat (3) step();
    rst = 0;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {pmem_read, pmem_write}, 2'b00);
    chk("rst_addr", pmem_address, 0);
    chk("rst_wdata", pmem_wdata, 0);
    chk("rst_resps", {i_resp, d_resp}, 2'b00);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    for (int i = 0; i < 6; i++) begin
      lat = v[i].lat;
      first_resp = -1;
      if (v[i].ir) req_i(v[i].ia);
      if (v[i].dr || v[i].dw) req_d(v[i].dr, v[i].dw, v[i].da, v[i].dwd);
      step();
      chk("grant_busy", busy, 1);
      chk("grant_addr", pmem_address, v[i].first != 0 ? {v[i].da[31:5], 5'b0} : {v[i].ia[31:5], 5'b0});
      drain("vec_timeout");
      chk("first_owner", first_resp, v[i].first);
      step();
    end
    stray = 1;
    step();
    chk("stray_resps", {i_resp, d_resp}, 2'b00);
    chk("stray_busy", busy, 0);
    stray = 0;
    step();
    chk("stray_after_busy", busy, 0);
    lat = 10;
    req_d(1'b0, 1'b1, 32'h0000_1000, {16{16'hBEEF}});
    step(); step();
    chk("mid_busy", busy, 1);
    rst = 1;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_strobes", {pmem_read, pmem_write}, 2'b00);
    chk("abort_d_resp", d_resp, 0);
    rst = 0; d_write = 0;
    dq.delete();
    step();
    chk("abort_idle_d_resp", d_resp, 0);
    lat = 2;
    c0 = i_count;
    req_i(32'h0000_2468);
    drain("post_reset_timeout");
    chk("post_reset_i_served", i_count - c0, 1);
    step();
    lat = 1;
    d_reissue = 10;
    d_count = 0;
    c0 = i_count;
    req_i(32'h0000_3000);
    req_d(1'b1, 1'b0, 32'h0000_4000, 256'b0);
    for (int k = 0; k < 100 && i_count == c0; k++) step();
    chk("starve_i_granted", i_count - c0, 1);
    chk("starve_d_grants", d_count, 4);
    d_reissue = 0;
    drain("starve_drain_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single cacheline-wide physical memory port between the instruction cache (read-only) and the data cache (read/write).
- The data cache is the one the load/store queue drains into.
- Grants one whole transaction at a time, routes the response back to the owner, and guarantees instruction fetch cannot be starved by a burst of data-side misses.
- Sits between both caches and the memory model/cacheline adapter.

Parameters:
STARVE_LIMIT, 8, number of cycles a pending I-side request may lose arbitration before it is forced to win the next tie.
D_FIRST, 1, tie-break when both request in IDLE: 1 = data cache wins (subject to STARVE_LIMIT), 0 = instruction cache wins.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_read  in  1  I-cache line read request, level-held until i_resp
i_address  in  32  I-cache line address
i_rdata  out  256  line returned to I-cache
i_resp  out  1  one-cycle completion pulse to I-cache
d_read  in  1  D-cache line read request, level-held until d_resp
d_write  in  1  D-cache line writeback request, level-held until d_resp
d_address  in  32  D-cache line address
d_wdata  in  256  writeback line
d_rdata  out  256  line returned to D-cache
d_resp  out  1  one-cycle completion pulse to D-cache
pmem_read  out  1  memory read strobe
pmem_write  out  1  memory write strobe
pmem_address  out  32  line-aligned memory address
pmem_wdata  out  256  memory write data
pmem_rdata  in  256  memory read data
pmem_resp  in  1  memory completion pulse
busy  out  1  high in any SERVE state

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. Reset state is IDLE.
- Reset values: all outputs 0; wait_cnt 0.
- rst mid-transaction: return to IDLE next edge. No resp is issued; the memory side is reset alongside.
- IDLE, with requests sampled at the clock edge:
  - No request: stay in IDLE.
  - Only I requests: go to SERVE_I.
  - Only D (read or write) requests: go to SERVE_D.
  - Both request: go to SERVE_D when D_FIRST=1 and wait_cnt < STARVE_LIMIT; otherwise go to SERVE_I.
  - pmem strobes are 0 in IDLE.
- SERVE_I:
  - pmem_read=1, pmem_write=0, pmem_address = {i_address[31:5],5'b0}.
  - When pmem_resp=1: i_resp=1 in the same cycle, i_rdata=pmem_rdata, next state IDLE.
- SERVE_D:
  - pmem_read=d_read & ~d_write, pmem_write=d_write, pmem_address = {d_address[31:5],5'b0}, pmem_wdata=d_wdata.
  - When pmem_resp=1: d_resp=1 in the same cycle, d_rdata=pmem_rdata (don't-care on writes), next state IDLE.
- Overlapping strobes: if d_read and d_write are both high, the write wins.
- A non-owner's resp is always 0. A pmem_resp arriving in IDLE is ignored.
- Grant is held until pmem_resp, even if the owner drops its request (protocol violation). The resp pulse is still issued.
- Latency and turnaround: minimum 1 IDLE cycle between consecutive transactions. Grant-to-strobe latency is 1 cycle from the request seen in IDLE.
- i_rdata/d_rdata are combinational passthrough of pmem_rdata, valid only while the matching resp is high.
- wait_cnt, width $clog2(STARVE_LIMIT+1):
  - Increments, saturating at STARVE_LIMIT, each cycle i_read=1 and state != SERVE_I.
  - Clears on entry to SERVE_I.
  - Holds when i_read=0.
- D_FIRST=0: I wins all ties and wait_cnt is unused (tied to 0).
- busy = (state != IDLE).

Test Plan:
- I-only read, addr 0x0000_1234, memory returns after 3 cycles -> pmem_read asserted with pmem_address 0x0000_1220 the cycle after the request; i_resp pulses for 1 cycle with line data; d_resp stays 0.
- D writeback, addr 0x8000_0040, wdata pattern A5.., d_read=1 also high -> pmem_write=1, pmem_read=0, pmem_wdata matches; d_resp pulses once; state returns to IDLE.
- Simultaneous I and D requests, D_FIRST=1, wait_cnt=0 -> SERVE_D first; after d_resp, 1 IDLE cycle; then SERVE_I.
- Starvation: D re-requests immediately after every d_resp and I holds i_read -> I is granted no later than the tie following wait_cnt reaching 8.
- rst asserted mid SERVE_D before pmem_resp -> next cycle state is IDLE, all strobes 0, no d_resp; a fresh I request is then served normally.
- Stray pmem_resp while in IDLE -> no i_resp/d_resp; state unchanged.
